// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the two-way intersection phase sequencer.
//   - phase_t    : light FSM state codes (also driven out on the phase port)
//   - RED/YEL/GRN: one-hot light encodings, {red,yellow,green}
//   - phase_dur  : how many ticks a given phase lasts
//   - next_phase : fixed phase rotation taken when a phase is allowed to end
// -----------------------------------------------------------------------------
package traffic_pkg;

   typedef enum logic [2:0] {
      ALL_RED_2 = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      ALL_RED_1 = 3'd3,
      EW_GREEN  = 3'd4,
      EW_YELLOW = 3'd5
   } phase_t;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   // Both greens share one duration, both yellows share one, and both
   // all-red clearances share one; any unused code falls back to all-red.
   function automatic int phase_dur(input phase_t p, input int t_green,
                                    input int t_yellow, input int t_allred);
      case (p)
         NS_GREEN, EW_GREEN:   return t_green;
         NS_YELLOW, EW_YELLOW: return t_yellow;
         default:              return t_allred;
      endcase
   endfunction

   // Rotation order; unused codes recover to the safe all-red state.
   function automatic phase_t next_phase(input phase_t p);
      case (p)
         ALL_RED_2: return NS_GREEN;
         NS_GREEN:  return NS_YELLOW;
         NS_YELLOW: return ALL_RED_1;
         ALL_RED_1: return EW_GREEN;
         EW_GREEN:  return EW_YELLOW;
         default:   return ALL_RED_2;
      endcase
   endfunction

endpackage

// File: rtl/comparatorgen_st.sv
// -----------------------------------------------------------------------------
// comparatorgen_st
// Generic WIDTH-bit equality comparator.
//   a, b : operands
//   eq   : 1 when a == b
// -----------------------------------------------------------------------------
module comparatorgen_st #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             eq
);

   assign eq = (a == b);

endmodule

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Tick-driven phase counter with terminal-count detection.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : timebase strobe; counter only moves when tick=1
//   clr        : restart the count at zero (phase is ending on this tick)
//   hold       : freeze the count even on a tick (phase expired but waiting)
//   dur_m1     : terminal value, phase duration minus one
//   done       : counter has reached dur_m1
// -----------------------------------------------------------------------------
module phase_timer #(
   parameter int NBITS = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             clr,
   input  logic             hold,
   input  logic [NBITS-1:0] dur_m1,
   output logic             done
);

   logic [NBITS-1:0] cnt;

   // Terminal count is a plain equality against duration-1, so a phase of
   // duration N is seen as done during its N-th tick.
   comparatorgen_st #(
      .WIDTH(NBITS)
   ) u_cmp (
      .a  (cnt),
      .b  (dur_m1),
      .eq (done)
   );

   // Clear wins over everything so the next phase starts at zero; hold keeps
   // an expired count parked at its terminal value instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (tick && !hold) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
// Phase sequencer for a two-way (NS/EW) intersection. NS green is the resting
// phase; EW is served only after a latched vehicle-sensor request.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : timebase strobe, phases are measured in ticks
//   ew_car     : EW vehicle sensor level, synchronous to clk
//   ns_light   : NS lamps {red,yellow,green}, one-hot
//   ew_light   : EW lamps {red,yellow,green}, one-hot
//   phase      : current state code
// Optional (macro TRAFFIC_PED_EN):
//   ped_req    : pedestrian push-button, latched like ew_car
//   ped_walk   : walk signal, lit for a whole EW green that served a ped call
// -----------------------------------------------------------------------------
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int NBITS    = 8,
   parameter int T_GREEN  = 8,
   parameter int T_YELLOW = 3,
   parameter int T_ALLRED = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       ew_car,
`ifdef TRAFFIC_PED_EN
   input  logic       ped_req,
   output logic       ped_walk,
`endif
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic [2:0] phase
);

   phase_t           state;
   logic             ew_req;
   logic             serve;
   logic             may_leave;
   logic             done;
   logic             step;
   logic             hold;
   logic             enter_ew;
   logic [NBITS-1:0] dur_m1;

   assign dur_m1 = NBITS'(phase_dur(state, T_GREEN, T_YELLOW, T_ALLRED) - 1);

`ifdef TRAFFIC_PED_EN
   logic ped_latch;
   assign serve = ew_req | ped_latch;
`else
   assign serve = ew_req;
`endif

   // NS green is the only phase that can outlast its timer: it waits for a
   // pending EW/pedestrian call. Every other phase leaves on terminal count.
   assign may_leave = (state != NS_GREEN) || serve;
   assign step      = tick && done && may_leave;
   assign hold      = done && !may_leave;
   assign enter_ew  = step && (state == ALL_RED_1);

   phase_timer #(
      .NBITS(NBITS)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .clr    (step),
      .hold   (hold),
      .dur_m1 (dur_m1),
      .done   (done)
   );

   // Light FSM plus the EW request latch. The latch clears on the edge that
   // starts EW green, and that clear beats a simultaneous set: a car arriving
   // right then is already being served by the green that is starting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ALL_RED_2;
         ew_req <= 1'b0;
      end else begin
         if (step) begin
            state <= next_phase(state);
         end
         if (enter_ew) begin
            ew_req <= 1'b0;
         end else if (ew_car) begin
            ew_req <= 1'b1;
         end
      end
   end

`ifdef TRAFFIC_PED_EN
   // Pedestrian call follows the same set/clear rules as the EW request.
   // Walk is decided once, on entry to EW green, and dropped when it ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ped_latch <= 1'b0;
         ped_walk  <= 1'b0;
      end else begin
         if (enter_ew) begin
            ped_latch <= 1'b0;
         end else if (ped_req) begin
            ped_latch <= 1'b1;
         end
         if (enter_ew) begin
            ped_walk <= ped_latch;
         end else if (step && (state == EW_GREEN)) begin
            ped_walk <= 1'b0;
         end
      end
   end
`endif

   // Lamps depend on the state register alone, so no input can glitch them
   // and reset forces all-red immediately.
   always_comb begin
      ns_light = RED;
      ew_light = RED;
      case (state)
         NS_GREEN:  ns_light = GRN;
         NS_YELLOW: ns_light = YEL;
         EW_GREEN:  ew_light = GRN;
         EW_YELLOW: ew_light = YEL;
         default: begin
            ns_light = RED;
            ew_light = RED;
         end
      endcase
   end

   assign phase = state;

endmodule
